// File: rtl/multi_slot_display_ctrl.sv
// ============================================================================
// multi_slot_display_ctrl
// ----------------------------------------------------------------------------
// Purpose:
//   Display front end that sits between the switch synchroniser / button
//   debouncers and seven_segment_display_subsystem. It keeps a small circular
//   store of captured switch values and lets the user step through them. Either
//   the live switch value or the currently viewed stored value is shown as hex
//   digits or as decimal (BCD) digits. The decimal digits come from a
//   sequential double-dabble engine that processes one operand bit per clock.
//
// Parameters:
//   DATA_W      width of value_in and of each stored slot (4..32)
//   DISP_DIGITS number of displayed digits
//   SLOTS       depth of the capture store (2..16)
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   value_in     synchronised switch value
//   store_pulse  one-cycle pulse: capture value_in into the store
//   next_pulse   one-cycle pulse: advance the viewed slot
//   mode         00 live hex, 01 live dec, 10 stored hex, 11 stored dec
//   disp_nibbles digit nibbles, [3:0] is the rightmost digit
//   disp_valid   disp_nibbles reflects the current source and mode
//   blank_mask   1 = digit should be blanked (leading-zero blanking)
//   overflow     source does not fit in DISP_DIGITS digits
//   busy         BCD engine is shifting
//   view_slot    slot index shown in the stored modes
//   slot_count   number of valid slots, saturating at SLOTS
//
// Build option:
//   LEADING_ZERO_BLANK_EN  when defined, decimal results blank the zero digits
//                          left of the most significant nonzero digit. When not
//                          defined, blank_mask is tied to zero.
// ============================================================================
module multi_slot_display_ctrl #(
    parameter int DATA_W      = 16,
    parameter int DISP_DIGITS = 4,
    parameter int SLOTS       = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [DATA_W-1:0]          value_in,
    input  logic                       store_pulse,
    input  logic                       next_pulse,
    input  logic [1:0]                 mode,
    output logic [4*DISP_DIGITS-1:0]   disp_nibbles,
    output logic                       disp_valid,
    output logic [DISP_DIGITS-1:0]     blank_mask,
    output logic                       overflow,
    output logic                       busy,
    output logic [$clog2(SLOTS)-1:0]   view_slot,
    output logic [$clog2(SLOTS+1)-1:0] slot_count
);

    // Number of BCD digits needed for DATA_W bits: ceil(DATA_W*log10(2)) + 1.
    function automatic int bcd_digits_needed(input int width);
        return (width * 30103 + 99999) / 100000 + 1;
    endfunction

    localparam int NIB_W      = 4 * DISP_DIGITS;
    localparam int PTR_W      = $clog2(SLOTS);
    localparam int CNT_W      = $clog2(SLOTS + 1);
    localparam int BCD_NEED   = bcd_digits_needed(DATA_W);
    // Always keep at least one digit above the displayed ones so the
    // overflow slice is never empty.
    localparam int ACC_DIGITS = (BCD_NEED > DISP_DIGITS) ? BCD_NEED : DISP_DIGITS + 1;
    localparam int ACC_W      = 4 * ACC_DIGITS;
    localparam int EXT_W      = (DATA_W > NIB_W) ? DATA_W : NIB_W;
    localparam int SH_W       = $clog2(DATA_W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [DATA_W-1:0] slots [SLOTS];
    logic [PTR_W-1:0]  wr_ptr;

    logic [DATA_W-1:0] source;
    logic [DATA_W-1:0] src_q;
    logic [1:0]        mode_q;
    logic              change;
    logic              is_dec;
    logic              start;
    logic              publish;

    logic [DATA_W-1:0] operand;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  acc_adj;
    logic [SH_W-1:0]   shift_cnt;

    logic [EXT_W-1:0]  src_ext;
    logic [NIB_W-1:0]  hex_nib;
    logic              hex_ovf;
    logic [NIB_W-1:0]  dec_nib;
    logic              dec_ovf;

    // Capture store: a store always takes priority over a next request, and
    // the freshly written slot becomes the one being viewed.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SLOTS; i++) begin
                slots[i] <= '0;
            end
            wr_ptr     <= '0;
            view_slot  <= '0;
            slot_count <= '0;
        end else if (store_pulse) begin
            slots[wr_ptr] <= value_in;
            wr_ptr        <= (wr_ptr == PTR_W'(SLOTS - 1)) ? '0 : wr_ptr + PTR_W'(1);
            view_slot     <= wr_ptr;
            if (slot_count < CNT_W'(SLOTS)) begin
                slot_count <= slot_count + CNT_W'(1);
            end
        end else if (next_pulse && (slot_count != '0)) begin
            if (CNT_W'(view_slot) + CNT_W'(1) >= slot_count) begin
                view_slot <= '0;
            end else begin
                view_slot <= view_slot + PTR_W'(1);
            end
        end
    end

    // Source selection; an empty store reads as zero.
    always_comb begin
        source = '0;
        if (!mode[1]) begin
            source = value_in;
        end else if (slot_count != '0) begin
            source = slots[view_slot];
        end
    end

    assign change = (source != src_q) || (mode != mode_q);
    assign is_dec = mode[0];

    // Hex digits are a direct slice of the zero-extended source.
    assign src_ext = EXT_W'(source);
    assign hex_nib = src_ext[NIB_W-1:0];
    assign hex_ovf = |(src_ext >> NIB_W);

    // Double-dabble correction step applied before each shift.
    always_comb begin
        acc_adj = acc;
        for (int d = 0; d < ACC_DIGITS; d++) begin
            if (acc[4*d +: 4] >= 4'd5) begin
                acc_adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
            end
        end
    end

    // A result that does not fit is shown as all nines.
    assign dec_ovf = |acc[ACC_W-1:NIB_W];
    assign dec_nib = dec_ovf ? {DISP_DIGITS{4'h9}} : acc[NIB_W-1:0];

    // Conversion FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. Any change restarts the conversion so a stale result
    // is never published; leaving the decimal modes drops back to IDLE.
    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        publish = 1'b0;
        case (state_q)
            IDLE: begin
                if (is_dec && change) begin
                    state_d = SHIFT;
                    start   = 1'b1;
                end
            end
            SHIFT: begin
                if (!is_dec) begin
                    state_d = IDLE;
                end else if (change) begin
                    state_d = SHIFT;
                    start   = 1'b1;
                end else if (shift_cnt == SH_W'(DATA_W - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!is_dec) begin
                    state_d = IDLE;
                end else if (change) begin
                    state_d = SHIFT;
                    start   = 1'b1;
                end else begin
                    state_d = IDLE;
                    publish = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = (state_q == SHIFT);

    // Change-detect registers, BCD datapath and display outputs. Hex modes
    // refresh the outputs every cycle; decimal modes only update on publish.
    always_ff @(posedge clk) begin
        if (reset) begin
            src_q        <= '0;
            mode_q       <= '0;
            operand      <= '0;
            acc          <= '0;
            shift_cnt    <= '0;
            disp_nibbles <= '0;
            disp_valid   <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            src_q  <= source;
            mode_q <= mode;
            if (!is_dec) begin
                disp_nibbles <= hex_nib;
                disp_valid   <= 1'b1;
                overflow     <= hex_ovf;
            end else if (start) begin
                operand    <= source;
                acc        <= '0;
                shift_cnt  <= '0;
                disp_valid <= 1'b0;
            end else if (state_q == SHIFT) begin
                acc       <= ACC_W'({acc_adj, operand[DATA_W-1]});
                operand   <= operand << 1;
                shift_cnt <= shift_cnt + SH_W'(1);
            end else if (publish) begin
                disp_nibbles <= dec_nib;
                overflow     <= dec_ovf;
                disp_valid   <= 1'b1;
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [DISP_DIGITS-1:0] dec_blank;
    logic [DISP_DIGITS-1:0] blank_q;
    logic                   seen_nonzero;

    // Blank every zero digit left of the first nonzero one, scanning from the
    // left; digit 0 is never blanked so a value of zero still shows "0".
    always_comb begin
        dec_blank    = '0;
        seen_nonzero = 1'b0;
        for (int d = DISP_DIGITS - 1; d >= 1; d--) begin
            if (dec_nib[4*d +: 4] != 4'h0) begin
                seen_nonzero = 1'b1;
            end
            dec_blank[d] = !seen_nonzero;
        end
    end

    // The mask moves in step with disp_nibbles.
    always_ff @(posedge clk) begin
        if (reset) begin
            blank_q <= '0;
        end else if (!is_dec) begin
            blank_q <= '0;
        end else if (publish) begin
            blank_q <= dec_blank;
        end
    end

    assign blank_mask = blank_q;
`else
    assign blank_mask = '0;
`endif

endmodule
